// File: rtl/dmem_responder_pkg.sv
// Shared types and decode helper for the data-memory responder.
// Note: no `ifdef feature switch lives here.
package dmem_responder_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR      = 3'd3,
        S_RMW_WR  = 3'd4,
        S_RESP    = 3'd5
    } dmem_state_e;

    typedef enum logic [1:0] {
        BYTE    = 2'd0,
        HALF    = 2'd1,
        WORD_SZ = 2'd2
    } mem_size_e;

    localparam logic [3:0] OPA_LS_REG   = 4'b0101;
    localparam logic [3:0] OPA_LS_IMM_W = 4'b0110;
    localparam logic [3:0] OPA_LS_IMM_B = 4'b0111;
    localparam logic [3:0] OPA_LS_IMM_H = 4'b1000;
    localparam logic [3:0] OPA_LS_SP    = 4'b1001;

    typedef struct packed {
        logic      valid;
        logic      load;
        mem_size_e size;
        logic      sign;
    } dmem_dec_t;

    // Maps a 7-bit {opA, opB} Thumb load/store opcode onto access attributes.
    function automatic dmem_dec_t decode_op(input logic [6:0] op);
        dmem_dec_t d;
        d.valid = 1'b1;
        d.load  = op[2];
        d.size  = WORD_SZ;
        d.sign  = 1'b0;
        case (op[6:3])
            OPA_LS_REG: begin
                case (op[2:0])
                    3'b000:  d.size = WORD_SZ;
                    3'b001:  d.size = HALF;
                    3'b010:  d.size = BYTE;
                    3'b011:  begin d.size = BYTE; d.sign = 1'b1; d.load = 1'b1; end
                    3'b100:  d.size = WORD_SZ;
                    3'b101:  d.size = HALF;
                    3'b110:  d.size = BYTE;
                    default: begin d.size = HALF; d.sign = 1'b1; end
                endcase
            end
            OPA_LS_IMM_W: d.size = WORD_SZ;
            OPA_LS_IMM_B: d.size = BYTE;
            OPA_LS_IMM_H: d.size = HALF;
            OPA_LS_SP:    d.size = WORD_SZ;
            default:      d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the memory pipeline stage (master) and the
// data-memory responder (slave). Signal names keep the responder's port view.
interface dmem_responder_if #(
    parameter int WORD = 32
) ();
    logic            req_valid_i;
    logic            req_ready_o;
    logic            req_write_i;
    logic [6:0]      req_opcode_i;
    logic [WORD-1:0] req_addr_i;
    logic [WORD-1:0] req_wdata_i;
    logic            resp_valid_o;
    logic            resp_ready_i;
    logic [WORD-1:0] resp_rdata_o;
    logic            resp_fault_o;

    modport master (
        output req_valid_i, req_write_i, req_opcode_i, req_addr_i, req_wdata_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_fault_o
    );

    modport slave (
        input  req_valid_i, req_write_i, req_opcode_i, req_addr_i, req_wdata_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_fault_o
    );
endinterface

// File: rtl/dmem_sram.sv
// Single-port word SRAM with one-cycle registered read; contents are not reset.
module dmem_sram #(
    parameter int WORD      = 32,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk_i,
    input  logic                 rd_en_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] idx_i,
    input  logic [WORD-1:0]      wdata_i,
    output logic [WORD-1:0]      rdata_o
);
    logic [WORD-1:0] mem_q [0:(2**ADDR_BITS)-1];
    logic [WORD-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
        if (rd_en_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, sub-word stores via read-modify-write.
// Define DMEM_ALIGN_CHECK_EN to fault misaligned half/word accesses instead of forcing alignment.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int WORD          = 32,
    parameter int MEM_ADDR_BITS = 8
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    dmem_responder_if.slave bus
);
    localparam int NB = WORD / 8;
    localparam int AW = MEM_ADDR_BITS + 2;

    dmem_state_e     state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [WORD-1:0] wdata_q, wdata_d;
    mem_size_e       size_q, size_d;
    logic            sign_q, sign_d;
    logic            load_q, load_d;
    logic [WORD-1:0] rdata_q, rdata_d;
    logic            fault_q, fault_d;

    dmem_dec_t       dec;
    logic            accept;
    logic            range_bad;
    logic            misalign;
    logic            req_fault;

    logic            sram_rd_en;
    logic            sram_we;
    logic [WORD-1:0] sram_wdata;
    logic [WORD-1:0] sram_rdata;
    logic [NB-1:0]   be;
    logic [WORD-1:0] lane_wdata;
    logic [WORD-1:0] merged;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [WORD-1:0] load_ext;

    assign dec       = decode_op(bus.req_opcode_i);
    assign accept    = bus.req_valid_i && (state_q == S_IDLE);
    assign range_bad = |bus.req_addr_i[WORD-1:AW];

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign = ((dec.size == HALF) && bus.req_addr_i[0]) ||
                      ((dec.size == WORD_SZ) && (bus.req_addr_i[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req_fault = !dec.valid || (bus.req_write_i == dec.load) || range_bad || misalign;

    // Byte enables for the merge; forced alignment falls out of ignoring low bits here.
    always_comb begin
        be = '0;
        case (size_q)
            BYTE:    be[addr_q[1:0]] = 1'b1;
            HALF:    begin
                be[{addr_q[1], 1'b0}] = 1'b1;
                be[{addr_q[1], 1'b1}] = 1'b1;
            end
            default: be = '1;
        endcase
    end

    assign lane_wdata = (size_q == BYTE) ? {NB{wdata_q[7:0]}} : {(NB/2){wdata_q[15:0]}};

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_merge
            assign merged[8*gi +: 8] = be[gi] ? lane_wdata[8*gi +: 8] : sram_rdata[8*gi +: 8];
        end
    endgenerate

    assign rd_byte = sram_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign rd_half = sram_rdata[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        case (size_q)
            BYTE:    load_ext = {{(WORD-8){sign_q & rd_byte[7]}}, rd_byte};
            HALF:    load_ext = {{(WORD-16){sign_q & rd_half[15]}}, rd_half};
            default: load_ext = sram_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        sign_d     = sign_q;
        load_d     = load_q;
        rdata_d    = rdata_q;
        fault_d    = fault_q;
        sram_rd_en = 1'b0;
        sram_we    = 1'b0;
        sram_wdata = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = bus.req_addr_i[AW-1:0];
                    wdata_d = bus.req_wdata_i;
                    size_d  = dec.size;
                    sign_d  = dec.sign;
                    load_d  = dec.load;
                    rdata_d = '0;
                    fault_d = req_fault;
                    if (req_fault) begin
                        state_d = S_RESP;
                    end else if (dec.load || (dec.size != WORD_SZ)) begin
                        state_d = S_RD;
                    end else begin
                        state_d = S_WR;
                    end
                end
            end
            S_RD: begin
                sram_rd_en = 1'b1;
                state_d    = load_q ? S_RD_DATA : S_RMW_WR;
            end
            S_RD_DATA: begin
                rdata_d = load_ext;
                state_d = S_RESP;
            end
            S_RMW_WR: begin
                sram_we    = 1'b1;
                sram_wdata = merged;
                state_d    = S_RESP;
            end
            S_WR: begin
                sram_we = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.resp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= WORD_SZ;
            sign_q  <= 1'b0;
            load_q  <= 1'b0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            load_q  <= load_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    dmem_sram #(
        .WORD      (WORD),
        .ADDR_BITS (MEM_ADDR_BITS)
    ) u_sram (
        .clk_i   (clk_i),
        .rd_en_i (sram_rd_en),
        .we_i    (sram_we),
        .idx_i   (addr_q[AW-1:2]),
        .wdata_i (sram_wdata),
        .rdata_o (sram_rdata)
    );

    assign bus.req_ready_o  = (state_q == S_IDLE);
    assign bus.resp_valid_o = (state_q == S_RESP);
    assign bus.resp_rdata_o = rdata_q;
    assign bus.resp_fault_o = fault_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic against a
// byte-addressed reference memory model.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if #(.WORD(32)) bus ();

    dmem_responder #(.WORD(32), .MEM_ADDR_BITS(8)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    byte unsigned ref_mem [0:1023];

    function automatic void ref_decode(input logic [6:0] op, output bit ok, output bit is_load,
                                       output int nbytes, output bit sgn);
        ok = 1; sgn = 0; is_load = op[2]; nbytes = 4;
        case (op[6:3])
            4'b0101: begin
                case (op[2:0])
                    3'd0: begin is_load = 0; nbytes = 4; end
                    3'd1: begin is_load = 0; nbytes = 2; end
                    3'd2: begin is_load = 0; nbytes = 1; end
                    3'd3: begin is_load = 1; nbytes = 1; sgn = 1; end
                    3'd4: begin is_load = 1; nbytes = 4; end
                    3'd5: begin is_load = 1; nbytes = 2; end
                    3'd6: begin is_load = 1; nbytes = 1; end
                    default: begin is_load = 1; nbytes = 2; sgn = 1; end
                endcase
            end
            4'b0110, 4'b1001: nbytes = 4;
            4'b0111: nbytes = 1;
            4'b1000: nbytes = 2;
            default: ok = 0;
        endcase
    endfunction

    // Reference: byte memory, little-endian, no memory change on fault.
    task automatic ref_access(input bit wr, input logic [6:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] rdata,
                              output bit fault, output int lat);
        bit ok, is_load, sgn;
        int nbytes, base;
        ref_decode(op, ok, is_load, nbytes, sgn);
        fault = !ok || (wr == is_load) || (addr >= 32'd1024);
`ifdef DMEM_ALIGN_CHECK_EN
        if (ok && (addr % nbytes) != 0) fault = 1;
`endif
        rdata = 32'h0;
        if (fault) begin
            lat = 1;
            return;
        end
        base = int'(addr) - (int'(addr) % nbytes);
        if (is_load) begin
            for (int i = 0; i < nbytes; i++) rdata[8*i +: 8] = ref_mem[base + i];
            if (sgn && rdata[8*nbytes-1]) begin
                for (int i = nbytes; i < 4; i++) rdata[8*i +: 8] = 8'hFF;
            end
            lat = 3;
        end else begin
            for (int i = 0; i < nbytes; i++) ref_mem[base + i] = wdata[8*i +: 8];
            lat = (nbytes == 4) ? 2 : 3;
        end
    endtask

    // Presents a request and returns the number of edges (accept edge included) until resp_valid.
    task automatic issue(input bit wr, input logic [6:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat);
        int w = 0;
        @(negedge clk);
        bus.req_valid_i  = 1'b1;
        bus.req_write_i  = wr;
        bus.req_opcode_i = op;
        bus.req_addr_i   = addr;
        bus.req_wdata_i  = wdata;
        while (!bus.req_ready_o && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: req_ready_o=%0b required 1", bus.req_ready_o);
        end
        @(posedge clk);
        lat = 1;
        #1 bus.req_valid_i = 1'b0;
        @(negedge clk);
        while (!bus.resp_valid_o && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!bus.resp_valid_o) lat = 99;
    endtask

    task automatic finish_resp();
        bus.resp_ready_i = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input bit wr, input logic [6:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] o_rdata, output logic o_fault,
                       output int o_lat, output logic [31:0] e_rdata, output bit e_fault,
                       output int e_lat);
        ref_access(wr, op, addr, wdata, e_rdata, e_fault, e_lat);
        bus.resp_ready_i = 1'b1;
        issue(wr, op, addr, wdata, o_lat);
        o_rdata = bus.resp_rdata_o;
        o_fault = bus.resp_fault_o;
        finish_resp();
        $display("txn wr=%0b op=%07b addr=%08h wdata=%08h -> rdata=%08h fault=%0b lat=%0d",
                 wr, op, addr, wdata, o_rdata, o_fault, o_lat);
    endtask

    task automatic test_reset();
        bus.req_valid_i = 0; bus.req_write_i = 0; bus.req_opcode_i = '0;
        bus.req_addr_i = '0; bus.req_wdata_i = '0; bus.resp_ready_i = 1;
        reset_n = 1'b0;
        #12;
        n_checks += 4;
        if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %0b want 1", bus.req_ready_o); end
        if (bus.resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %0b want 0", bus.resp_valid_o); end
        if (bus.resp_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %08h want 0", bus.resp_rdata_o); end
        if (bus.resp_fault_o !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %0b want 0", bus.resp_fault_o); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_init();
        logic [31:0] r, er; logic f; bit ef; int l, el;
        for (int i = 0; i < 256; i++) begin
            run(1, 7'b0101000, 32'(i * 4), $urandom, r, f, l, er, ef, el);
            n_checks++;
            if (f !== 1'b0 || l != 2) begin
                n_fail++;
                $display("FAIL init_str: fault=%0b lat=%0d want fault=0 lat=2", f, l);
            end
        end
    endtask

    task automatic test_word_subword();
        logic [6:0]  ops [10]   = '{7'b0101000, 7'b0101100, 7'b0101000, 7'b0101010, 7'b0101100,
                                    7'b0101011, 7'b0101110, 7'b1000000, 7'b0101111, 7'b0101101};
        logic [31:0] adrs [10]  = '{32'h10, 32'h10, 32'h10, 32'h11, 32'h10, 32'h11, 32'h11, 32'h22, 32'h22, 32'h22};
        logic [31:0] wds [10]   = '{32'hDEADBEEF, 0, 32'h11223344, 32'h000000A5, 0, 0, 0, 32'h00008001, 0, 0};
        logic [31:0] exp_r [10] = '{0, 32'hDEADBEEF, 0, 0, 32'h1122A544, 32'hFFFFFFA5, 32'h000000A5, 0, 32'hFFFF8001, 32'h00008001};
        int          exp_l [10] = '{2, 3, 2, 3, 3, 3, 3, 3, 3, 3};
        bit          wrs [10]   = '{1, 0, 1, 1, 0, 0, 0, 1, 0, 0};
        logic [31:0] r, er; logic f; bit ef; int l, el;
        for (int i = 0; i < 10; i++) begin
            run(wrs[i], ops[i], adrs[i], wds[i], r, f, l, er, ef, el);
            n_checks += 3;
            if (r !== exp_r[i]) begin n_fail++; $display("FAIL ws_rdata[%0d]: got %08h want %08h", i, r, exp_r[i]); end
            if (f !== 1'b0) begin n_fail++; $display("FAIL ws_fault[%0d]: got %0b want 0", i, f); end
            if (l != exp_l[i]) begin n_fail++; $display("FAIL ws_latency[%0d]: got %0d want %0d", i, l, exp_l[i]); end
        end
    endtask

    task automatic test_faults();
        logic [6:0]  ops [4]  = '{7'b0101100, 7'b0000000, 7'b0101100, 7'b0101000};
        logic [31:0] adrs [4] = '{32'h400, 32'h10, 32'h10, 32'h400};
        bit          wrs [4]  = '{0, 0, 1, 1};
        logic [31:0] r, er; logic f; bit ef; int l, el;
        for (int i = 0; i < 4; i++) begin
            run(wrs[i], ops[i], adrs[i], 32'hBAD0BAD0, r, f, l, er, ef, el);
            n_checks += 3;
            if (f !== 1'b1) begin n_fail++; $display("FAIL fault_flag[%0d]: got %0b want 1", i, f); end
            if (r !== 32'h0) begin n_fail++; $display("FAIL fault_rdata[%0d]: got %08h want 0", i, r); end
            if (l != 1) begin n_fail++; $display("FAIL fault_latency[%0d]: got %0d want 1", i, l); end
            run(0, 7'b0101100, adrs[i] & 32'h3FC, 0, r, f, l, er, ef, el);
            n_checks++;
            if (r !== er || f !== 1'b0) begin
                n_fail++;
                $display("FAIL fault_no_side_effect[%0d]: got %08h/%0b want %08h/0", i, r, f, er);
            end
        end
    endtask

    task automatic test_misalign();
        logic [6:0]  ops [2]  = '{7'b0101100, 7'b0101101};
        logic [31:0] adrs [2] = '{32'h13, 32'h23};
        logic [31:0] r, er; logic f; bit ef; int l, el;
        for (int i = 0; i < 2; i++) begin
            run(0, ops[i], adrs[i], 0, r, f, l, er, ef, el);
            n_checks += 3;
            if (f !== logic'(ef)) begin n_fail++; $display("FAIL misalign_fault[%0d]: got %0b want %0b", i, f, ef); end
            if (r !== er) begin n_fail++; $display("FAIL misalign_rdata[%0d]: got %08h want %08h", i, r, er); end
            if (l != el) begin n_fail++; $display("FAIL misalign_latency[%0d]: got %0d want %0d", i, l, el); end
        end
    endtask

    task automatic test_hold();
        logic [31:0] er; bit ef; int el, l;
        logic [31:0] r0; logic f0;
        int tmp;
        ref_access(1, 7'b0101000, 32'h40, 32'h0BADCAFE, er, ef, el);
        bus.resp_ready_i = 1'b1;
        issue(1, 7'b0101000, 32'h40, 32'h0BADCAFE, tmp);
        finish_resp();
        ref_access(0, 7'b0101100, 32'h40, 0, er, ef, el);
        bus.resp_ready_i = 1'b0;
        issue(0, 7'b0101100, 32'h40, 0, l);
        r0 = bus.resp_rdata_o;
        f0 = bus.resp_fault_o;
        n_checks++;
        if (r0 !== 32'h0BADCAFE) begin n_fail++; $display("FAIL hold_rdata: got %08h want 0badcafe", r0); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks += 4;
            if (bus.resp_valid_o !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %0b want 1", c, bus.resp_valid_o); end
            if (bus.resp_rdata_o !== r0) begin n_fail++; $display("FAIL hold_data[%0d]: got %08h want %08h", c, bus.resp_rdata_o, r0); end
            if (bus.resp_fault_o !== f0) begin n_fail++; $display("FAIL hold_fault[%0d]: got %0b want %0b", c, bus.resp_fault_o, f0); end
            if (bus.req_ready_o !== 1'b0) begin n_fail++; $display("FAIL hold_req_ready[%0d]: got %0b want 0", c, bus.req_ready_o); end
        end
        finish_resp();
        @(negedge clk);
        n_checks += 2;
        if (bus.resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL hold_release_valid: got %0b want 0", bus.resp_valid_o); end
        if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL hold_release_ready: got %0b want 1", bus.req_ready_o); end
        $display("txn hold LDR addr=00000040 -> rdata=%08h held 5 cycles", r0);
    endtask

    task automatic test_reset_mid();
        logic [31:0] r, er; logic f; bit ef; int l, el;
        bus.resp_ready_i = 1'b0;
        @(negedge clk);
        bus.req_valid_i = 1; bus.req_write_i = 1; bus.req_opcode_i = 7'b0101010;
        bus.req_addr_i = 32'h31; bus.req_wdata_i = 32'h0000005A;
        @(posedge clk);
        #1 bus.req_valid_i = 0;
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        n_checks += 4;
        if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL midrst_req_ready: got %0b want 1", bus.req_ready_o); end
        if (bus.resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %0b want 0", bus.resp_valid_o); end
        if (bus.resp_rdata_o !== 32'h0) begin n_fail++; $display("FAIL midrst_rdata: got %08h want 0", bus.resp_rdata_o); end
        if (bus.resp_fault_o !== 1'b0) begin n_fail++; $display("FAIL midrst_fault: got %0b want 0", bus.resp_fault_o); end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        $display("txn STRB addr=00000031 aborted by reset in RMW_WR");
        run(0, 7'b0101100, 32'h30, 0, r, f, l, er, ef, el);
        n_checks++;
        if (r !== er) begin n_fail++; $display("FAIL midrst_word_unchanged: got %08h want %08h", r, er); end
    endtask

    task automatic test_random();
        logic [31:0] r, er, addr; logic f; bit ef; int l, el;
        logic [6:0] op; bit wr, ok, ld, sg; int nb;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) op = 7'($urandom);
            else op = {4'($urandom_range(5, 9)), 3'($urandom)};
            ref_decode(op, ok, ld, nb, sg);
            wr = !ld;
            if ($urandom_range(0, 9) == 0) wr = !wr;
            addr = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 9) == 0) addr = addr | (32'h1 << $urandom_range(10, 31));
            run(wr, op, addr, $urandom, r, f, l, er, ef, el);
            n_checks += 3;
            if (r !== er) begin n_fail++; $display("FAIL rand_rdata[%0d]: got %08h want %08h", i, r, er); end
            if (f !== logic'(ef)) begin n_fail++; $display("FAIL rand_fault[%0d]: got %0b want %0b", i, f, ef); end
            if (l != el) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, l, el); end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_word_subword();
        test_faults();
        test_misalign();
        test_hold();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
